// File: rtl/eth_crc_pkg.sv
// Shared CRC-32 constants, FSM state type and the single-nibble CRC update
// used by the Ethernet FCS engine.
package eth_crc_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  // Wide enough to count the 8 nibble words of an MII FCS.
  localparam int EMIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } fcs_state_t;

  function automatic logic [31:0] crc32_nibble(input logic [31:0] crc,
                                               input logic [3:0]  nib);
    logic [31:0] c;
    c = crc ^ {28'h0, nib};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_nstep.sv
// Combinational CRC-32 update over NSTEPS nibbles, lowest nibble first.
module crc32_nstep #(
  parameter int NSTEPS = 2
) (
  input  logic [31:0]         crc_in,
  input  logic [4*NSTEPS-1:0] data,
  output logic [31:0]         crc_out
);
  import eth_crc_pkg::*;

  for (genvar g = 0; g < NSTEPS; g++) begin : g_step
    logic [31:0] c_in;
    logic [31:0] c_out;
    if (g == 0) begin : g_first
      assign c_in = crc_in;
    end else begin : g_chain
      assign c_in = g_step[g-1].c_out;
    end
    assign c_out = crc32_nibble(c_in, data[4*g +: 4]);
  end

  assign crc_out = g_step[NSTEPS-1].c_out;

endmodule

// File: rtl/eth_fcs_engine.sv
// Streaming Ethernet FCS engine: one-cycle passthrough, CRC accumulation,
// optional FCS append (TX) and residue check (RX).
module eth_fcs_engine #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sof,
  input  logic              eof,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              append_fcs,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              fcs_valid,
  output logic [31:0]       fcs_value,
  output logic              fcs_ok,
  output logic              frame_abort
);
  import eth_crc_pkg::*;

  localparam int NSTEPS = DATA_W / 4;
  localparam int NWORDS = 32 / DATA_W;
  localparam logic [EMIT_CNT_W-1:0] EMIT_LAST = EMIT_CNT_W'(NWORDS - 1);

  if (!(DATA_W == 4 || DATA_W == 8)) begin : g_bad_width
    $error("eth_fcs_engine: DATA_W must be 4 or 8");
  end

  fcs_state_t              state_q, state_d;
  logic [31:0]             crc_q, crc_d, crc_base, crc_next;
  logic [31:0]             sr_q, sr_d;
  logic [EMIT_CNT_W-1:0]   emit_cnt_q, emit_cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    fcs_valid_q, fcs_valid_d;
  logic [31:0]             fcs_value_q, fcs_value_d;
  logic                    fcs_ok_q, fcs_ok_d;
  logic                    frame_abort_q, frame_abort_d;
  logic                    accept;
  logic                    close_frame;

  assign accept   = in_valid & in_ready_q;
  assign crc_base = sof ? CRC32_INIT : crc_q;

  crc32_nstep #(.NSTEPS(NSTEPS)) u_crc (
    .crc_in  (crc_base),
    .data    (in_data),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    sr_d          = sr_q;
    emit_cnt_d    = emit_cnt_q;
    out_valid_d   = 1'b0;
    out_data_d    = '0;
    fcs_valid_d   = 1'b0;
    fcs_value_d   = fcs_value_q;
    fcs_ok_d      = fcs_ok_q;
    frame_abort_d = 1'b0;
    close_frame   = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end

    case (state_q)
      IDLE: begin
        // Words outside a frame pass through but never touch the CRC.
        if (accept && sof) begin
          crc_d       = crc_next;
          state_d     = ACCUM;
          close_frame = eof;
        end
      end
      ACCUM: begin
        if (accept) begin
          crc_d         = crc_next;
          frame_abort_d = sof;
          close_frame   = eof;
        end
      end
      EMIT: begin
        out_valid_d = 1'b1;
        out_data_d  = sr_q[DATA_W-1:0];
        sr_d        = sr_q >> DATA_W;
        if (emit_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          emit_cnt_d = emit_cnt_q - EMIT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (close_frame) begin
      fcs_valid_d = 1'b1;
      fcs_value_d = ~crc_next;
      fcs_ok_d    = (crc_next == CRC32_RESIDUE);
      crc_d       = CRC32_INIT;
      if (append_fcs) begin
        state_d    = EMIT;
        sr_d       = ~crc_next;
        emit_cnt_d = EMIT_LAST;
      end else begin
        state_d = IDLE;
      end
    end

    in_ready_d = (state_d != EMIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      crc_q         <= CRC32_INIT;
      sr_q          <= '0;
      emit_cnt_q    <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      fcs_valid_q   <= 1'b0;
      fcs_value_q   <= '0;
      fcs_ok_q      <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      sr_q          <= sr_d;
      emit_cnt_q    <= emit_cnt_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      fcs_valid_q   <= fcs_valid_d;
      fcs_value_q   <= fcs_value_d;
      fcs_ok_q      <= fcs_ok_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign fcs_valid   = fcs_valid_q;
  assign fcs_value   = fcs_value_q;
  assign fcs_ok      = fcs_ok_q;
  assign frame_abort = frame_abort_q;

endmodule
